note_hit_judge: RTL and testbench

Scoring stage that sits directly downstream of the per-lane button synchronizer/rising-edge detectors in GuitarVillains. It takes one-cycle fret-press pulses per lane and one-cycle "note reached strike line" strobes from the note scroller. It judges each note as hit or miss inside a timing window, flags stray presses, and maintains score, combo and best combo for the display logic.

---
 rtl/note_hit_judge.sv | 153 +++++++++++++++
 tb/tb_note_hit_judge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_hit_judge.sv
// rtl/note_hit_judge.sv - per-lane hit/miss/stray judge with saturating score and combo
module note_hit_judge #(
   parameter int LANES         = 4,
   parameter int WINDOW_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] press,
   input  logic [LANES-1:0] note_due,
   input  logic             enable,
   input  logic             clear_score,
   output logic [LANES-1:0] hit,
   output logic [LANES-1:0] miss,
   output logic [LANES-1:0] stray,
   output logic [15:0]      score,
   output logic [7:0]       combo,
   output logic [7:0]       max_combo
);

   typedef enum logic {IDLE, OPEN} lane_state_e;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WINDOW_CYCLES - 1);

   lane_state_e      state_q [LANES];
   lane_state_e      state_d [LANES];
   logic [CNT_W-1:0] cnt_q   [LANES];
   logic [CNT_W-1:0] cnt_d   [LANES];

   logic [LANES-1:0] hit_q, hit_d, miss_q, miss_d, stray_q, stray_d;
   logic [15:0]      score_q, score_d;
   logic [7:0]       combo_q, combo_d, max_q, max_d;

   logic [7:0]       h_cnt;
   logic [7:0]       mult;
   logic [16:0]      add;
   logic [16:0]      score_sum;
   logic [8:0]       combo_sum;
   logic [7:0]       combo_new;
   logic             bad;

   // Per-lane window FSM: judge each note once, press wins over expiry
   always_comb begin
      hit_d   = '0;
      miss_d  = '0;
      stray_d = '0;
      for (int i = 0; i < LANES; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (!enable) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (note_due[i] && press[i]) begin
                     hit_d[i] = 1'b1;
                  end else if (note_due[i]) begin
                     state_d[i] = OPEN;
                     cnt_d[i]   = RELOAD;
                  end else if (press[i]) begin
                     stray_d[i] = 1'b1;
                  end
               end
               OPEN: begin
                  if (press[i]) begin
                     hit_d[i] = 1'b1;
                     if (note_due[i]) begin
                        cnt_d[i] = RELOAD;
                     end else begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                     end
                  end else if (note_due[i]) begin
                     miss_d[i] = 1'b1;
                     cnt_d[i]  = RELOAD;
                  end else if (cnt_q[i] == '0) begin
                     miss_d[i]  = 1'b1;
                     state_d[i] = IDLE;
                  end else begin
                     cnt_d[i] = cnt_q[i] - 1'b1;
                  end
               end
               default: begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // Score/combo update from last cycle's registered judgements
   always_comb begin
      h_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         h_cnt = h_cnt + 8'(hit_q[i]);
      end
      bad       = |(miss_q | stray_q);
      mult      = (combo_q < 8'd10) ? 8'd1 : (combo_q < 8'd30) ? 8'd2 : 8'd4;
      add       = 17'(h_cnt) * 17'(mult);
      score_sum = {1'b0, score_q} + add;
      combo_sum = {1'b0, combo_q} + {1'b0, h_cnt};
      combo_new = bad ? 8'd0 : (combo_sum[8] ? 8'hFF : combo_sum[7:0]);
      score_d   = score_q;
      combo_d   = combo_q;
      max_d     = max_q;
      if (clear_score) begin
         score_d = '0;
         combo_d = '0;
         max_d   = '0;
      end else if (enable) begin
         score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         combo_d = combo_new;
         max_d   = (combo_new > max_q) ? combo_new : max_q;
      end
   end

   // State, counters, pulse and score registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         hit_q   <= '0;
         miss_q  <= '0;
         stray_q <= '0;
         score_q <= '0;
         combo_q <= '0;
         max_q   <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         stray_q <= stray_d;
         score_q <= score_d;
         combo_q <= combo_d;
         max_q   <= max_d;
      end
   end

   assign hit       = hit_q;
   assign miss      = miss_q;
   assign stray     = stray_q;
   assign score     = score_q;
   assign combo     = combo_q;
   assign max_combo = max_q;

endmodule

// File: tb/tb_note_hit_judge.sv
// tb/tb_note_hit_judge.sv - directed self-checking bench for note_hit_judge
module tb_note_hit_judge;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] press;
   logic [3:0] note_due;
   logic       enable;
   logic       clear_score;
   logic [3:0] hit, miss, stray;
   logic [15:0] score;
   logic [7:0] combo, max_combo;

   int n_pass  = 0;
   int n_total = 0;

   note_hit_judge #(.LANES(4), .WINDOW_CYCLES(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .press(press), .note_due(note_due),
      .enable(enable), .clear_score(clear_score),
      .hit(hit), .miss(miss), .stray(stray),
      .score(score), .combo(combo), .max_combo(max_combo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [3:0] p, input logic [3:0] n);
      press    = p;
      note_due = n;
      tick();
      press    = '0;
      note_due = '0;
   endtask

   task automatic idle(input int k);
      for (int j = 0; j < k; j++) cyc(4'd0, 4'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      press = '0; note_due = '0; enable = 1'b1; clear_score = 1'b0; rst = 1'b0;
      do_reset();
      chk("rst_hit", 32'(hit), 0);
      chk("rst_miss", 32'(miss), 0);
      chk("rst_stray", 32'(stray), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_combo", 32'(combo), 0);
      chk("rst_max", 32'(max_combo), 0);

      // note at T, press at T+3
      cyc(4'b0000, 4'b0001);
      idle(2);
      cyc(4'b0001, 4'b0000);
      chk("a_hit", 32'(hit), 32'h1);
      idle(1);
      chk("a_hit_gone", 32'(hit), 0);
      chk("a_score", 32'(score), 1);
      chk("a_combo", 32'(combo), 1);

      // lane 2 expires at T+8
      cyc(4'b0000, 4'b0100);
      idle(7);
      chk("b_no_early_miss", 32'(miss), 0);
      idle(1);
      chk("b_miss", 32'(miss), 32'h4);
      idle(1);
      chk("b_miss_gone", 32'(miss), 0);
      chk("b_combo", 32'(combo), 0);
      chk("b_score", 32'(score), 1);
      chk("b_max", 32'(max_combo), 1);

      // press exactly at T+8 is still a hit
      cyc(4'b0000, 4'b0100);
      idle(7);
      cyc(4'b0100, 4'b0000);
      chk("c_hit_edge", 32'(hit), 32'h4);
      chk("c_no_miss", 32'(miss), 0);
      idle(1);
      chk("c_no_late_miss", 32'(miss), 0);
      chk("c_score", 32'(score), 2);
      chk("c_combo", 32'(combo), 1);

      // build combo to 5 then stray on lane 1
      for (int j = 0; j < 4; j++) cyc(4'b0001, 4'b0001);
      idle(1);
      chk("d_combo5", 32'(combo), 5);
      chk("d_score6", 32'(score), 6);
      cyc(4'b0010, 4'b0000);
      chk("d_stray", 32'(stray), 32'h2);
      idle(1);
      chk("d_combo0", 32'(combo), 0);
      chk("d_score_held", 32'(score), 6);
      chk("d_max5", 32'(max_combo), 5);

      // second note while OPEN: miss, window restarts
      cyc(4'b0000, 4'b0010);
      idle(3);
      cyc(4'b0000, 4'b0010);
      chk("e_restart_miss", 32'(miss), 32'h2);
      idle(5);
      cyc(4'b0010, 4'b0000);
      chk("e_hit_t10", 32'(hit), 32'h2);
      chk("e_no_miss", 32'(miss), 0);
      idle(1);
      chk("e_score", 32'(score), 7);
      chk("e_combo", 32'(combo), 1);

      // multiplier tiers
      do_reset();
      for (int j = 0; j < 30; j++) cyc(4'b0001, 4'b0001);
      idle(1);
      chk("f_score50", 32'(score), 50);
      chk("f_combo30", 32'(combo), 30);
      cyc(4'b0001, 4'b0001);
      idle(1);
      chk("f_score54", 32'(score), 54);
      cyc(4'b0000, 4'b0001);
      cyc(4'b0000, 4'b0001);
      chk("f_miss", 32'(miss), 32'h1);
      idle(1);
      chk("f_combo0", 32'(combo), 0);
      chk("f_max31", 32'(max_combo), 31);
      chk("f_score_kept", 32'(score), 54);

      // simultaneous hits and miss at combo 12
      do_reset();
      for (int j = 0; j < 12; j++) cyc(4'b0001, 4'b0001);
      cyc(4'b0000, 4'b0010);
      chk("g_combo12", 32'(combo), 12);
      chk("g_score14", 32'(score), 14);
      cyc(4'b1001, 4'b1011);
      chk("g_hit", 32'(hit), 32'h9);
      chk("g_miss", 32'(miss), 32'h2);
      idle(1);
      chk("g_score18", 32'(score), 18);
      chk("g_combo0", 32'(combo), 0);
      chk("g_max12", 32'(max_combo), 12);

      // score saturation
      do_reset();
      cyc(4'b0001, 4'b0001);
      cyc(4'b0001, 4'b0001);
      for (int j = 0; j < 4099; j++) cyc(4'b1111, 4'b1111);
      cyc(4'b0111, 4'b0111);
      idle(1);
      chk("s_score_fffe", 32'(score), 32'hFFFE);
      chk("s_combo_sat", 32'(combo), 255);
      cyc(4'b0011, 4'b0011);
      idle(1);
      chk("s_score_ffff", 32'(score), 32'hFFFF);

      // reset in the middle of a window
      do_reset();
      cyc(4'b0000, 4'b0001);
      idle(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
         idle(1);
         chk("h_no_miss_after_rst", 32'(miss), 0);
      end
      cyc(4'b0001, 4'b0000);
      chk("h_stray_after_rst", 32'(stray), 32'h1);
      chk("h_hit_after_rst", 32'(hit), 0);

      // enable low: no pulses, score held, lanes forced idle
      do_reset();
      cyc(4'b0001, 4'b0001);
      idle(1);
      chk("i_score1", 32'(score), 1);
      cyc(4'b0000, 4'b0001);
      enable = 1'b0;
      cyc(4'b0001, 4'b0001);
      chk("i_hit_dis", 32'(hit), 0);
      cyc(4'b0010, 4'b0000);
      chk("i_stray_dis", 32'(stray), 0);
      cyc(4'b0000, 4'b0100);
      idle(1);
      chk("i_score_held", 32'(score), 1);
      chk("i_combo_held", 32'(combo), 1);
      enable = 1'b1;
      for (int j = 0; j < 10; j++) begin
         idle(1);
         chk("i_no_miss", 32'(miss), 0);
      end

      // clear_score beats a same-cycle hit
      cyc(4'b0001, 4'b0001);
      chk("j_hit", 32'(hit), 32'h1);
      clear_score = 1'b1;
      tick();
      clear_score = 1'b0;
      chk("j_score0", 32'(score), 0);
      chk("j_combo0", 32'(combo), 0);
      chk("j_max0", 32'(max_combo), 0);
      idle(1);
      chk("j_score_stays0", 32'(score), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
